fifo_route_top: RTL and testbench

Nibble datapath. An input FIFO captures a 4-bit stream every cycle, and a transfer stage moves words into an output FIFO, optionally XOR-masked by a steered lane. The output FIFO is drained by an external read enable. Bit/nibble demultiplexers and registered output multiplexers expose data, lanes, counts and status for observation/debug.

---
 rtl/fifo_route_pkg.sv | 37 +++
 rtl/fifo_route_if.sv | 43 ++++
 rtl/sync_fifo_fwft.sv | 58 +++++
 rtl/fifo_route_top.sv | 110 +++++++++++
 tb/tb_fifo_route_top.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_route_pkg.sv
// Shared widths, default depths, select-code enums and the flag-vector helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_route_pkg;

    localparam int DATA_W        = 4;
    localparam int IN_DEPTH_DEF  = 8;
    localparam int OUT_DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        SEL9_OUT_HEAD = 2'd0,
        SEL9_LANE_A   = 2'd1,
        SEL9_LANE_B   = 2'd2,
        SEL9_IN_HEAD  = 2'd3
    } sel9_e;

    typedef enum logic [1:0] {
        SEL6_LAST_D   = 2'd0,
        SEL6_LANE_AND = 2'd1,
        SEL6_IN_CNT   = 2'd2,
        SEL6_OUT_CNT  = 2'd3
    } sel6_e;

    typedef enum logic [1:0] {
        SEL16_IN_EMPTY  = 2'd0,
        SEL16_IN_STATUS = 2'd1,
        SEL16_OUT_EMPTY = 2'd2,
        SEL16_OUT_FULL  = 2'd3
    } sel16_e;

    // Two single-bit demultiplexers OR-ed into one 8-bit flag vector.
    function automatic logic [7:0] flag_vec(input logic b1, input logic [2:0] s1,
                                            input logic b2, input logic [2:0] s2);
        return ({7'b0, b1} << s1) | ({7'b0, b2} << s2);
    endfunction

endpackage

// File: rtl/fifo_route_if.sv
// Bundles the nibble stream, read enable, lane/select controls and observation outputs.
// Latency: n/a (wiring only).
// Backpressure: none carried here; the output FIFO is drained by in_outFIFO_inReadEnable.
interface fifo_route_if;
    import fifo_route_pkg::*;

    logic [DATA_W-1:0] in_inFIFO_inData;
    logic              in_outFIFO_inReadEnable;
    logic              in_DEMUX_inDEMUX1;
    logic              in_DEMUX_inDEMUX2;
    logic [DATA_W-1:0] in_DEMUX_inDEMUX17;
    logic [DATA_W-1:0] in_DEMUX_inDEMUX18;
    logic [2:0]        in_DEMUX_inSEL1;
    logic [2:0]        in_DEMUX_inSEL2;
    logic              in_MUX_inSEL3;
    logic [1:0]        in_MUX_inSEL6;
    logic [1:0]        in_MUX_inSEL9;
    logic              in_MUX_inSEL11;
    logic              in_MUX_inSEL12;
    logic [2:0]        in_MUX_inSEL15;
    logic              in_DEMUX_inSEL17;
    logic [DATA_W-1:0] out_MUX_outMUX9;
    logic [DATA_W-1:0] out_MUX_outMUX10;
    logic              out_MUX_outMUX15;
    logic              out_MUX_outMUX16;

    modport master (
        output in_inFIFO_inData, in_outFIFO_inReadEnable,
        output in_DEMUX_inDEMUX1, in_DEMUX_inDEMUX2, in_DEMUX_inDEMUX17, in_DEMUX_inDEMUX18,
        output in_DEMUX_inSEL1, in_DEMUX_inSEL2, in_MUX_inSEL3, in_MUX_inSEL6, in_MUX_inSEL9,
        output in_MUX_inSEL11, in_MUX_inSEL12, in_MUX_inSEL15, in_DEMUX_inSEL17,
        input  out_MUX_outMUX9, out_MUX_outMUX10, out_MUX_outMUX15, out_MUX_outMUX16
    );

    modport slave (
        input  in_inFIFO_inData, in_outFIFO_inReadEnable,
        input  in_DEMUX_inDEMUX1, in_DEMUX_inDEMUX2, in_DEMUX_inDEMUX17, in_DEMUX_inDEMUX18,
        input  in_DEMUX_inSEL1, in_DEMUX_inSEL2, in_MUX_inSEL3, in_MUX_inSEL6, in_MUX_inSEL9,
        input  in_MUX_inSEL11, in_MUX_inSEL12, in_MUX_inSEL15, in_DEMUX_inSEL17,
        output out_MUX_outMUX9, out_MUX_outMUX10, out_MUX_outMUX15, out_MUX_outMUX16
    );

endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; head word visible on rd_dat while !empty.
// Latency: a word pushed at edge N is on rd_dat after edge N.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module sync_fifo_fwft #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic                       rd_en,
    input  logic [WIDTH-1:0]           wr_dat,
    output logic [WIDTH-1:0]           rd_dat,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;
    logic             w_push;

    assign empty  = (r_count == '0);
    assign full   = (r_count == CW'(DEPTH));
    assign count  = r_count;
    assign rd_dat = r_mem[r_rptr];
    // A pop frees a slot this cycle, so a full FIFO can still accept a write.
    assign w_pop  = rd_en && !empty;
    assign w_push = wr_en && (!full || w_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; reads of stale slots are masked by empty downstream.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= wr_dat;
    end

endmodule

// File: rtl/fifo_route_top.sv
// Input FIFO -> optional lane XOR -> output FIFO, with registered debug/observation muxes.
// Latency: input word reaches outMUX9 (sel 0, out FIFO empty) two edges after it is written.
// Backpressure: transfer stalls while the output FIFO is full; input writes drop when full. Optional macro FIFO_ROUTE_OVF_FLAG_EN.
module fifo_route_top
    import fifo_route_pkg::*;
#(
    parameter int IN_DEPTH  = IN_DEPTH_DEF,
    parameter int OUT_DEPTH = OUT_DEPTH_DEF
) (
    input  logic           inClock,
    input  logic           inReset,
    fifo_route_if.slave    bus
);
    localparam int IN_CW  = $clog2(IN_DEPTH+1);
    localparam int OUT_CW = $clog2(OUT_DEPTH+1);

    logic [DATA_W-1:0] w_in_dat, w_out_dat, w_wr_dat;
    logic              w_in_empty, w_in_full, w_out_empty, w_out_full;
    logic [IN_CW-1:0]  w_in_cnt;
    logic [OUT_CW-1:0] w_out_cnt;
    logic              w_xfer, w_in_status;
    logic [DATA_W-1:0] w_lane_a, w_lane_b;
    logic [7:0]        w_vec;
    logic [DATA_W-1:0] w_mux9_nxt, w_mux10_nxt;
    logic              w_mux16_nxt;
    logic [DATA_W-1:0] r_last_d, r_mux9, r_mux10;
    logic              r_mux15, r_mux16;

    assign w_xfer   = !w_in_empty && !w_out_full;
    assign w_lane_a = bus.in_DEMUX_inSEL17 ? bus.in_DEMUX_inDEMUX18 : bus.in_DEMUX_inDEMUX17;
    assign w_lane_b = bus.in_DEMUX_inSEL17 ? bus.in_DEMUX_inDEMUX17 : bus.in_DEMUX_inDEMUX18;
    assign w_wr_dat = bus.in_MUX_inSEL3 ? (w_in_dat ^ w_lane_a) : w_in_dat;
    assign w_vec    = flag_vec(bus.in_DEMUX_inDEMUX1, bus.in_DEMUX_inSEL1,
                               bus.in_DEMUX_inDEMUX2, bus.in_DEMUX_inSEL2);

    sync_fifo_fwft #(.WIDTH(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk(inClock), .rst_n(inReset),
        .wr_en(1'b1), .rd_en(w_xfer), .wr_dat(bus.in_inFIFO_inData),
        .rd_dat(w_in_dat), .empty(w_in_empty), .full(w_in_full), .count(w_in_cnt)
    );

    sync_fifo_fwft #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk(inClock), .rst_n(inReset),
        .wr_en(w_xfer), .rd_en(bus.in_outFIFO_inReadEnable), .wr_dat(w_wr_dat),
        .rd_dat(w_out_dat), .empty(w_out_empty), .full(w_out_full), .count(w_out_cnt)
    );

`ifdef FIFO_ROUTE_OVF_FLAG_EN
    logic r_ovf;
    // Sticky overflow: set when the input is full and nothing pops it; only reset clears it.
    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset)                  r_ovf <= 1'b0;
        else if (w_in_full && !w_xfer) r_ovf <= 1'b1;
    end
    assign w_in_status = r_ovf;
`else
    assign w_in_status = w_in_full;
`endif

    // Select next values for the registered observation muxes.
    always_comb begin
        w_mux9_nxt  = '0;
        w_mux10_nxt = '0;
        w_mux16_nxt = 1'b0;
        case (sel9_e'(bus.in_MUX_inSEL9))
            SEL9_OUT_HEAD: w_mux9_nxt = w_out_empty ? '0 : w_out_dat;
            SEL9_LANE_A:   w_mux9_nxt = w_lane_a;
            SEL9_LANE_B:   w_mux9_nxt = w_lane_b;
            SEL9_IN_HEAD:  w_mux9_nxt = w_in_empty ? '0 : w_in_dat;
            default:       w_mux9_nxt = '0;
        endcase
        case (sel6_e'(bus.in_MUX_inSEL6))
            SEL6_LAST_D:   w_mux10_nxt = r_last_d;
            SEL6_LANE_AND: w_mux10_nxt = w_lane_a & w_lane_b;
            SEL6_IN_CNT:   w_mux10_nxt = DATA_W'(w_in_cnt);
            SEL6_OUT_CNT:  w_mux10_nxt = DATA_W'(w_out_cnt);
            default:       w_mux10_nxt = '0;
        endcase
        case (sel16_e'({bus.in_MUX_inSEL12, bus.in_MUX_inSEL11}))
            SEL16_IN_EMPTY:  w_mux16_nxt = w_in_empty;
            SEL16_IN_STATUS: w_mux16_nxt = w_in_status;
            SEL16_OUT_EMPTY: w_mux16_nxt = w_out_empty;
            SEL16_OUT_FULL:  w_mux16_nxt = w_out_full;
            default:         w_mux16_nxt = 1'b0;
        endcase
    end

    // Capture the last transferred input word and register every observation output.
    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) begin
            r_last_d <= '0;
            r_mux9   <= '0;
            r_mux10  <= '0;
            r_mux15  <= 1'b0;
            r_mux16  <= 1'b0;
        end else begin
            if (w_xfer) r_last_d <= w_in_dat;
            r_mux9  <= w_mux9_nxt;
            r_mux10 <= w_mux10_nxt;
            r_mux15 <= w_vec[bus.in_MUX_inSEL15];
            r_mux16 <= w_mux16_nxt;
        end
    end

    assign bus.out_MUX_outMUX9  = r_mux9;
    assign bus.out_MUX_outMUX10 = r_mux10;
    assign bus.out_MUX_outMUX15 = r_mux15;
    assign bus.out_MUX_outMUX16 = r_mux16;

endmodule

// File: tb/tb_fifo_route_top.sv
// Scoreboard bench: queue-based model of both FIFOs tracks every edge; tasks compare inline.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: modelled in the reference queues (transfer stall, input drop).
module tb_fifo_route_top;
    import fifo_route_pkg::*;

    localparam int IN_D  = 8;
    localparam int OUT_D = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_route_if bus();

    fifo_route_top #(.IN_DEPTH(IN_D), .OUT_DEPTH(OUT_D)) dut (
        .inClock(clk),
        .inReset(rst_n),
        .bus(bus)
    );

    int n_run = 0;
    int n_fail = 0;
    int edge_n = 0;

    logic [3:0] m_in_q[$];
    logic [3:0] m_out_q[$];
    logic [3:0] m_last = 4'h0;
    bit         m_ovf = 1'b0;
    logic [9:0] m_exp = 10'h0;
    wire  [9:0] w_obs = {bus.out_MUX_outMUX9, bus.out_MUX_outMUX10,
                         bus.out_MUX_outMUX15, bus.out_MUX_outMUX16};

    task automatic model_clear();
        m_in_q.delete();
        m_out_q.delete();
        m_last = 4'h0;
        m_ovf  = 1'b0;
        m_exp  = 10'h0;
    endtask

    task automatic drive_defaults();
        bus.in_inFIFO_inData        = 4'h0;
        bus.in_outFIFO_inReadEnable = 1'b0;
        bus.in_DEMUX_inDEMUX1       = 1'b0;
        bus.in_DEMUX_inDEMUX2       = 1'b0;
        bus.in_DEMUX_inDEMUX17      = 4'h0;
        bus.in_DEMUX_inDEMUX18      = 4'h0;
        bus.in_DEMUX_inSEL1         = 3'd0;
        bus.in_DEMUX_inSEL2         = 3'd0;
        bus.in_MUX_inSEL3           = 1'b0;
        bus.in_MUX_inSEL6           = 2'd0;
        bus.in_MUX_inSEL9           = 2'd0;
        bus.in_MUX_inSEL11          = 1'b0;
        bus.in_MUX_inSEL12          = 1'b0;
        bus.in_MUX_inSEL15          = 3'd0;
        bus.in_DEMUX_inSEL17        = 1'b0;
    endtask

    // One rising edge: expected registered outputs come from pre-edge model state.
    task automatic tick();
        logic [3:0] la, lb, d, w, e9, e10;
        logic [7:0] v;
        logic       e16;
        bit         xfer, pop_o, in_full;
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            la = bus.in_DEMUX_inSEL17 ? bus.in_DEMUX_inDEMUX18 : bus.in_DEMUX_inDEMUX17;
            lb = bus.in_DEMUX_inSEL17 ? bus.in_DEMUX_inDEMUX17 : bus.in_DEMUX_inDEMUX18;
            case (bus.in_MUX_inSEL9)
                2'd0:    e9 = (m_out_q.size() != 0) ? m_out_q[0] : 4'h0;
                2'd1:    e9 = la;
                2'd2:    e9 = lb;
                default: e9 = (m_in_q.size() != 0) ? m_in_q[0] : 4'h0;
            endcase
            case (bus.in_MUX_inSEL6)
                2'd0:    e10 = m_last;
                2'd1:    e10 = la & lb;
                2'd2:    e10 = 4'(m_in_q.size());
                default: e10 = 4'(m_out_q.size());
            endcase
            v = 8'h0;
            if (bus.in_DEMUX_inDEMUX1) v[bus.in_DEMUX_inSEL1] = 1'b1;
            if (bus.in_DEMUX_inDEMUX2) v[bus.in_DEMUX_inSEL2] = 1'b1;
            in_full = (m_in_q.size() == IN_D);
            case ({bus.in_MUX_inSEL12, bus.in_MUX_inSEL11})
                2'b00:   e16 = (m_in_q.size() == 0);
`ifdef FIFO_ROUTE_OVF_FLAG_EN
                2'b01:   e16 = m_ovf;
`else
                2'b01:   e16 = in_full;
`endif
                2'b10:   e16 = (m_out_q.size() == 0);
                default: e16 = (m_out_q.size() == OUT_D);
            endcase
            m_exp = {e9, e10, v[bus.in_MUX_inSEL15], e16};
            xfer  = (m_in_q.size() != 0) && (m_out_q.size() != OUT_D);
            pop_o = bus.in_outFIFO_inReadEnable && (m_out_q.size() != 0);
            w = 4'h0;
            if (xfer) begin
                d = m_in_q.pop_front();
                w = bus.in_MUX_inSEL3 ? (d ^ la) : d;
                m_last = d;
            end
            if (pop_o) void'(m_out_q.pop_front());
            if (xfer) m_out_q.push_back(w);
            if (!in_full || xfer) m_in_q.push_back(bus.in_inFIFO_inData);
            else m_ovf = 1'b1;
            edge_n++;
        end
        #1;
    endtask

    task automatic restart();
        rst_n = 1'b0;
        model_clear();
        drive_defaults();
        tick();
        tick();
        rst_n = 1'b1;
        edge_n = 0;
    endtask

    task automatic test_reset();
        drive_defaults();
        bus.in_inFIFO_inData  = 4'hD;
        bus.in_DEMUX_inDEMUX2 = 1'b1;
        rst_n = 1'b0;
        model_clear();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_run++;
            if (w_obs !== 10'h0) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: got %h required 000", i, w_obs);
            end
        end
        rst_n = 1'b1;
        edge_n = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_run++;
            if (w_obs !== m_exp) begin
                n_fail++;
                $display("FAIL reset_release edge %0d: got %h required %h", edge_n, w_obs, m_exp);
            end
        end
        n_run++;
        if (bus.out_MUX_outMUX9 !== 4'hD) begin
            n_fail++;
            $display("FAIL first_word_mux9: got %h required d", bus.out_MUX_outMUX9);
        end
        n_run++;
        if (bus.out_MUX_outMUX10 !== 4'hD) begin
            n_fail++;
            $display("FAIL first_last_d: got %h required d", bus.out_MUX_outMUX10);
        end
        n_run++;
        if ({bus.out_MUX_outMUX15, bus.out_MUX_outMUX16} !== 2'b10) begin
            n_fail++;
            $display("FAIL first_flags: got %b%b required 10", bus.out_MUX_outMUX15, bus.out_MUX_outMUX16);
        end
    endtask

    task automatic test_empty_read();
        restart();
        bus.in_inFIFO_inData        = 4'h3;
        bus.in_outFIFO_inReadEnable = 1'b1;
        bus.in_MUX_inSEL6           = 2'd3;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_run++;
            if (w_obs !== m_exp) begin
                n_fail++;
                $display("FAIL empty_read edge %0d: got %h required %h", edge_n, w_obs, m_exp);
            end
        end
        n_run++;
        if (bus.out_MUX_outMUX10 !== 4'h1) begin
            n_fail++;
            $display("FAIL empty_read_count: got %h required 1", bus.out_MUX_outMUX10);
        end
    endtask

    task automatic test_fill();
        restart();
        bus.in_inFIFO_inData = 4'hD;
        bus.in_MUX_inSEL6    = 2'd3;
        while (edge_n < 16) begin
            tick();
            n_run++;
            if (w_obs !== m_exp) begin
                n_fail++;
                $display("FAIL fill edge %0d: got %h required %h", edge_n, w_obs, m_exp);
            end
            if (edge_n == 10) begin
                n_run++;
                if (bus.out_MUX_outMUX10 !== 4'h8) begin
                    n_fail++;
                    $display("FAIL fill_out_count: got %h required 8", bus.out_MUX_outMUX10);
                end
            end
        end
        bus.in_MUX_inSEL6 = 2'd2;
        tick();
        n_run++;
        if (bus.out_MUX_outMUX10 !== 4'h8) begin
            n_fail++;
            $display("FAIL fill_in_count: got %h required 8", bus.out_MUX_outMUX10);
        end
        {bus.in_MUX_inSEL12, bus.in_MUX_inSEL11} = 2'b11;
        tick();
        n_run++;
        if (bus.out_MUX_outMUX16 !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_out_full: got %b required 1", bus.out_MUX_outMUX16);
        end
        {bus.in_MUX_inSEL12, bus.in_MUX_inSEL11} = 2'b01;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_run++;
            if (bus.out_MUX_outMUX16 !== 1'b1 || w_obs !== m_exp) begin
                n_fail++;
                $display("FAIL fill_in_status edge %0d: got %h required %h", edge_n, w_obs, m_exp);
            end
        end
    endtask

    task automatic test_read_full();
        logic [3:0] req [3] = '{4'h8, 4'h7, 4'h8};
        bus.in_MUX_inSEL6 = 2'd3;
        for (int i = 0; i < 3; i++) begin
            bus.in_outFIFO_inReadEnable = (i == 0);
            tick();
            n_run++;
            if (bus.out_MUX_outMUX10 !== req[i] || w_obs !== m_exp) begin
                n_fail++;
                $display("FAIL read_full step %0d: got %h required count %h model %h",
                         i, w_obs, req[i], m_exp);
            end
        end
    endtask

    task automatic test_xor_lanes();
        restart();
        bus.in_MUX_inSEL3           = 1'b1;
        bus.in_DEMUX_inDEMUX17      = 4'hF;
        bus.in_inFIFO_inData        = 4'h5;
        bus.in_outFIFO_inReadEnable = 1'b1;
        for (int phase = 0; phase < 2; phase++) begin
            if (phase == 1) begin
                bus.in_DEMUX_inSEL17   = 1'b1;
                bus.in_DEMUX_inDEMUX18 = 4'h3;
            end
            for (int i = 0; i < 5; i++) begin
                tick();
                n_run++;
                if (w_obs !== m_exp) begin
                    n_fail++;
                    $display("FAIL xor phase %0d edge %0d: got %h required %h", phase, edge_n, w_obs, m_exp);
                end
            end
            n_run++;
            if (bus.out_MUX_outMUX9 !== ((phase == 0) ? 4'hA : 4'h6)) begin
                n_fail++;
                $display("FAIL xor_word phase %0d: got %h required %h", phase,
                         bus.out_MUX_outMUX9, (phase == 0) ? 4'hA : 4'h6);
            end
        end
    endtask

    task automatic test_flags();
        bus.in_DEMUX_inDEMUX1 = 1'b1;
        bus.in_DEMUX_inSEL1   = 3'd5;
        bus.in_DEMUX_inDEMUX2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.in_MUX_inSEL15 = 3'(i);
            tick();
            n_run++;
            if (bus.out_MUX_outMUX15 !== (i == 5)) begin
                n_fail++;
                $display("FAIL flag_sweep sel %0d: got %b required %b", i, bus.out_MUX_outMUX15, (i == 5));
            end
        end
        bus.in_DEMUX_inDEMUX2 = 1'b1;
        bus.in_DEMUX_inSEL2   = 3'd2;
        bus.in_MUX_inSEL15    = 3'd2;
        tick();
        n_run++;
        if (bus.out_MUX_outMUX15 !== 1'b1) begin
            n_fail++;
            $display("FAIL flag_demux2: got %b required 1", bus.out_MUX_outMUX15);
        end
    endtask

    task automatic test_mid_reset();
        restart();
        bus.in_MUX_inSEL6 = 2'd3;
        for (int i = 0; i < 14; i++) begin
            bus.in_inFIFO_inData        = 4'($urandom_range(0, 15));
            bus.in_outFIFO_inReadEnable = ($urandom_range(0, 3) == 0);
            bus.in_MUX_inSEL9           = 2'($urandom_range(0, 3));
            tick();
            n_run++;
            if (w_obs !== m_exp) begin
                n_fail++;
                $display("FAIL busy edge %0d: got %h required %h", edge_n, w_obs, m_exp);
            end
        end
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        n_run++;
        if (w_obs !== 10'h0) begin
            n_fail++;
            $display("FAIL async_reset: got %h required 000", w_obs);
        end
        tick();
        drive_defaults();
        bus.in_inFIFO_inData  = 4'hD;
        bus.in_DEMUX_inDEMUX2 = 1'b1;
        rst_n = 1'b1;
        edge_n = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_run++;
            if (w_obs !== m_exp) begin
                n_fail++;
                $display("FAIL post_reset edge %0d: got %h required %h", edge_n, w_obs, m_exp);
            end
        end
        n_run++;
        if (bus.out_MUX_outMUX9 !== 4'hD) begin
            n_fail++;
            $display("FAIL post_reset_word: got %h required d", bus.out_MUX_outMUX9);
        end
    endtask

    initial begin
        drive_defaults();
        test_reset();
        test_empty_read();
        test_fill();
        test_read_full();
        test_xor_lanes();
        test_flags();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
